// File: rtl/pipe_stage_skid_reg_pkg.sv
// rtl/pipe_stage_skid_reg_pkg.sv - shared state encoding, default widths and reset level for the skid stage
package pipe_stage_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int PAYLOAD_W_DEF = 200;
    localparam int DATA_W_DEF    = 64;
    localparam int REGADDR_W_DEF = 5;

    // Reset is active-low throughout this stage.
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/pipe_stage_skid_reg_stage_entry_reg.sv
// rtl/pipe_stage_skid_reg_stage_entry_reg.sv - one pipeline entry (payload, rd_ena, rd_addr, fwd_data) with load enable
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset (clears all fields)
//   load               capture the d_* inputs this cycle; otherwise hold
//   d_payload ...      next entry contents
//   q_payload ...      held entry contents
module stage_entry_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REGADDR_W = REGADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic                 d_rd_ena,
    input  logic [REGADDR_W-1:0] d_rd_addr,
    input  logic [DATA_W-1:0]    d_fwd_data,
    output logic [PAYLOAD_W-1:0] q_payload,
    output logic                 q_rd_ena,
    output logic [REGADDR_W-1:0] q_rd_addr,
    output logic [DATA_W-1:0]    q_fwd_data
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            q_payload  <= '0;
            q_rd_ena   <= 1'b0;
            q_rd_addr  <= '0;
            q_fwd_data <= '0;
        end else if (load) begin
            q_payload  <= d_payload;
            q_rd_ena   <= d_rd_ena;
            q_rd_addr  <= d_rd_addr;
            q_fwd_data <= d_fwd_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - valid/ready pipeline stage with 2-entry skid buffer, flush and bypass export
//
// Optional: define STAGE_PERF_CNT_EN to add perf_stall_cnt / perf_flush_cnt.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   flush                     synchronous kill of all held entries
//   in_valid/in_ready         upstream handshake (in_ready registered)
//   in_payload, in_rd_*       upstream entry, in_fwd_data result for bypass
//   out_valid/out_ready       downstream handshake on the head entry
//   out_payload, out_rd_*     head entry (out_rd_ena qualified by out_valid)
//   fwd_valid/rd_addr/data    bypass view, slot 0 = head, slot 1 = skid
//   perf_stall_cnt            (optional) cycles with out_valid & !out_ready
//   perf_flush_cnt            (optional) flushes that killed live entries
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REGADDR_W = REGADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic                   in_rd_ena,
    input  logic [REGADDR_W-1:0]   in_rd_addr,
    input  logic [DATA_W-1:0]      in_fwd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic                   out_rd_ena,
    output logic [REGADDR_W-1:0]   out_rd_addr,
    output logic [DATA_W-1:0]      out_fwd_data,
    output logic [1:0]             fwd_valid,
    output logic [2*REGADDR_W-1:0] fwd_rd_addr,
    output logic [2*DATA_W-1:0]    fwd_data
`ifdef STAGE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);

    state_t state, state_nxt;
    logic   in_ready_q;
    logic   in_fire, out_fire;
    logic   head_load, skid_load, head_from_skid;

    logic [PAYLOAD_W-1:0] head_payload, skid_payload, head_d_payload;
    logic                 head_rd_ena, skid_rd_ena, head_d_rd_ena;
    logic [REGADDR_W-1:0] head_rd_addr, skid_rd_addr, head_d_rd_addr;
    logic [DATA_W-1:0]    head_fwd_data, skid_fwd_data, head_d_fwd_data;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            // Any concurrent in_fire is dropped; an out_fire is already taken downstream.
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // in_ready is the registered image of the next state so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
        end
    end

    assign head_d_payload  = head_from_skid ? skid_payload  : in_payload;
    assign head_d_rd_ena   = head_from_skid ? skid_rd_ena   : in_rd_ena;
    assign head_d_rd_addr  = head_from_skid ? skid_rd_addr  : in_rd_addr;
    assign head_d_fwd_data = head_from_skid ? skid_fwd_data : in_fwd_data;

    stage_entry_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .DATA_W    (DATA_W),
        .REGADDR_W (REGADDR_W)
    ) u_head (
        .clk        (clk),
        .rst        (rst),
        .load       (head_load),
        .d_payload  (head_d_payload),
        .d_rd_ena   (head_d_rd_ena),
        .d_rd_addr  (head_d_rd_addr),
        .d_fwd_data (head_d_fwd_data),
        .q_payload  (head_payload),
        .q_rd_ena   (head_rd_ena),
        .q_rd_addr  (head_rd_addr),
        .q_fwd_data (head_fwd_data)
    );

    stage_entry_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .DATA_W    (DATA_W),
        .REGADDR_W (REGADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .d_payload  (in_payload),
        .d_rd_ena   (in_rd_ena),
        .d_rd_addr  (in_rd_addr),
        .d_fwd_data (in_fwd_data),
        .q_payload  (skid_payload),
        .q_rd_ena   (skid_rd_ena),
        .q_rd_addr  (skid_rd_addr),
        .q_fwd_data (skid_fwd_data)
    );

    assign out_payload  = head_payload;
    assign out_rd_ena   = out_valid & head_rd_ena;
    assign out_rd_addr  = head_rd_addr;
    assign out_fwd_data = head_fwd_data;

    // Writes to x0 are never forwarded.
    assign fwd_valid[0] = out_valid & head_rd_ena & (|head_rd_addr);
    assign fwd_valid[1] = (state == ST_FULL) & skid_rd_ena & (|skid_rd_addr);
    assign fwd_rd_addr  = {skid_rd_addr, head_rd_addr};
    assign fwd_data     = {skid_fwd_data, head_fwd_data};

`ifdef STAGE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush && (state != ST_EMPTY) && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - self-checking bench for pipe_stage_skid_reg against a queue reference model
module tb_pipe_stage_skid_reg;

    localparam int PW = 32;
    localparam int DW = 64;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PW-1:0]   in_payload = '0;
    logic            in_rd_ena = 1'b0;
    logic [AW-1:0]   in_rd_addr = '0;
    logic [DW-1:0]   in_fwd_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PW-1:0]   out_payload;
    logic            out_rd_ena;
    logic [AW-1:0]   out_rd_addr;
    logic [DW-1:0]   out_fwd_data;
    logic [1:0]      fwd_valid;
    logic [2*AW-1:0] fwd_rd_addr;
    logic [2*DW-1:0] fwd_data;
`ifdef STAGE_PERF_CNT_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .PAYLOAD_W (PW),
        .DATA_W    (DW),
        .REGADDR_W (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_payload   (in_payload),
        .in_rd_ena    (in_rd_ena),
        .in_rd_addr   (in_rd_addr),
        .in_fwd_data  (in_fwd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_payload  (out_payload),
        .out_rd_ena   (out_rd_ena),
        .out_rd_addr  (out_rd_addr),
        .out_fwd_data (out_fwd_data),
        .fwd_valid    (fwd_valid),
        .fwd_rd_addr  (fwd_rd_addr),
        .fwd_data     (fwd_data)
`ifdef STAGE_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic [PW-1:0] payload;
        logic          rd_ena;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];      // entries held by the stage, oldest first
    logic [AW-1:0] got[$];    // rd_addr observed at each out_fire
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fwd_ok(input ent_t e);
        return e.rd_ena && (e.rd_addr != '0);
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("fwd_valid0", fwd_valid[0], (q.size() > 0) ? fwd_ok(q[0]) : 1'b0);
        chk("fwd_valid1", fwd_valid[1], (q.size() > 1) ? fwd_ok(q[1]) : 1'b0);
        if (q.size() > 0) begin
            chk("out_payload", out_payload, q[0].payload);
            chk("out_rd_ena", out_rd_ena, q[0].rd_ena);
            chk("out_rd_addr", out_rd_addr, q[0].rd_addr);
            chk("out_fwd_data", out_fwd_data, q[0].data);
            chk("fwd_rd_addr0", fwd_rd_addr[AW-1:0], q[0].rd_addr);
            chk("fwd_data0", fwd_data[DW-1:0], q[0].data);
        end else begin
            chk("out_rd_ena_empty", out_rd_ena, 1'b0);
        end
        if (q.size() > 1) begin
            chk("fwd_rd_addr1", fwd_rd_addr[2*AW-1:AW], q[1].rd_addr);
            chk("fwd_data1", fwd_data[2*DW-1:DW], q[1].data);
        end
    endtask

    // One clock: check outputs, drive inputs, advance model on the edge.
    task automatic cycle(input logic iv, input logic ordy, input logic fl,
                         input logic [PW-1:0] pl, input logic re,
                         input logic [AW-1:0] ra, input logic [DW-1:0] fd);
        ent_t e;
        logic m_in_fire, m_out_fire;
        check_outputs();
        in_valid    = iv;
        out_ready   = ordy;
        flush       = fl;
        in_payload  = pl;
        in_rd_ena   = re;
        in_rd_addr  = ra;
        in_fwd_data = fd;
        e.payload = pl;
        e.rd_ena  = re;
        e.rd_addr = ra;
        e.data    = fd;
        m_in_fire  = iv && (q.size() < 2);
        m_out_fire = ordy && (q.size() > 0);
        if (m_out_fire) got.push_back(out_rd_addr);
        @(posedge clk);
        if (m_out_fire) void'(q.pop_front());
        if (fl) q.delete();
        else if (m_in_fire) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, ordy, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 2'b00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_rd_ena", out_rd_ena, 1'b0);
        q.delete();
        @(negedge clk);
        chk("rst_out_payload", out_payload, '0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Power-on reset
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("por_out_valid", out_valid, 1'b0);
        chk("por_in_ready", in_ready, 1'b1);
        chk("por_fwd_valid", fwd_valid, 2'b00);
        chk("por_out_payload", out_payload, '0);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-stream with both entries full
        cycle(1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 5'd1, 64'h1);
        cycle(1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 5'd2, 64'h2);
        chk("pre_rst_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'hA5, 1'b1, 5'd9, 64'h9);
        chk("a5_out_valid", out_valid, 1'b1);
        chk("a5_out_payload", out_payload, 32'hA5);
        idle(1'b1);

        // Streaming rd 1..8
        got.delete();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h100 + i, 1'b1, AW'(i), 64'(i * 3));
            chk("stream_in_ready", in_ready, 1'b1);
        end
        idle(1'b1);
        chk("stream_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("stream_order", got[i], AW'(i + 1));

        // Backpressure: A (rd 3) then B (rd 4)
        got.delete();
        cycle(1'b1, 1'b0, 1'b0, 32'hAAAA, 1'b1, 5'd3, 64'hA);
        cycle(1'b1, 1'b0, 1'b0, 32'hBBBB, 1'b1, 5'd4, 64'hB);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_fwd_valid", fwd_valid, 2'b11);
        chk("bp_fwd_rd_addr", fwd_rd_addr, 10'h083);
        idle(1'b1);
        chk("bp_in_ready_after_a", in_ready, 1'b1);
        chk("bp_head_b", out_payload, 32'hBBBB);
        idle(1'b1);
        chk("bp_order", {got[0], got[1]}, {5'd3, 5'd4});
        chk("bp_drained", out_valid, 1'b0);

        // Flush in FULL with concurrent C
        cycle(1'b1, 1'b0, 1'b0, 32'hD1, 1'b1, 5'd5, 64'h5);
        cycle(1'b1, 1'b0, 1'b0, 32'hD2, 1'b1, 5'd6, 64'h6);
        cycle(1'b1, 1'b0, 1'b1, 32'hCC, 1'b1, 5'd7, 64'hC);
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_out_rd_ena", out_rd_ena, 1'b0);
        chk("fl_fwd_valid", fwd_valid, 2'b00);
        idle(1'b1);
        chk("fl_no_c", out_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, '0, 1'b0, '0, '0);   // flush while empty
        chk("fl_empty_noop", in_ready, 1'b1);

        // Forward masking of x0
        cycle(1'b1, 1'b0, 1'b0, 32'hF0, 1'b1, 5'd0, 64'hDEAD);
        chk("mask_x0", fwd_valid[0], 1'b0);
        cycle(1'b0, 1'b1, 1'b1, '0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, 32'hF7, 1'b1, 5'd7, 64'hDEAD);
        chk("mask_r7", fwd_valid[0], 1'b1);
        chk("mask_r7_data", fwd_data[DW-1:0], 64'hDEAD);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0), $urandom, 1'($urandom_range(0, 1)),
                  AW'($urandom), {$urandom, $urandom});
        end
        idle(1'b1);
        idle(1'b1);
        check_outputs();

`ifdef STAGE_PERF_CNT_EN
        in_valid = 1'b0;
        flush    = 1'b0;
        do_reset();
        chk("perf_stall_rst", perf_stall_cnt, 32'd0);
        chk("perf_flush_rst", perf_flush_cnt, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 5'd2, 64'h2);
        for (int i = 0; i < 5; i++) idle(1'b0);
        cycle(1'b0, 1'b1, 1'b1, '0, 1'b0, '0, '0);
        chk("perf_stall", perf_stall_cnt, 32'd5);
        chk("perf_flush", perf_flush_cnt, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor of the fixed-field LS->WB pipeline register.
- Generic stage boundary with valid/ready handshake and a 2-entry skid buffer (head + skid), so upstream ready never depends combinationally on downstream ready.
- Flush has priority over all other activity.
- Exports per-entry forwarding (rd address/data) to the decode-stage bypass network.
- Instantiated between any two pipeline stages (EX/LS, LS/WB).

Parameters:
- PAYLOAD_W, 200, width of opaque stage payload (inst, pc, ctl, csr fields concatenated by the instantiator)
- DATA_W, 64, forwarding data width
- REGADDR_W, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_payload  in  PAYLOAD_W  upstream payload
- in_rd_ena  in  1  entry writes rd
- in_rd_addr  in  REGADDR_W  destination register
- in_fwd_data  in  DATA_W  result value for bypass
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_payload  out  PAYLOAD_W  head payload
- out_rd_ena  out  1  head_valid AND head rd_ena
- out_rd_addr  out  REGADDR_W  head rd address
- out_fwd_data  out  DATA_W  head result value
- fwd_valid  out  2  [0]=head, [1]=skid; entry valid AND rd_ena AND rd_addr!=0
- fwd_rd_addr  out  2*REGADDR_W  [REGADDR_W-1:0]=head, upper=skid
- fwd_data  out  2*DATA_W  same packing as fwd_rd_addr

Behaviour:
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=0, async): state EMPTY, all valid bits 0, all payload/addr/data registers 0. Therefore out_valid=0, out_rd_ena=0, fwd_valid=2'b00, in_ready=1 immediately. Reset mid-transfer discards both entries.
- Per-cycle outputs:
  - in_ready = (state != FULL), from a register.
  - out_valid = (state != EMPTY).
  - out_* driven from the head registers.
- State EMPTY:
  - in_fire -> head<=in; go ONE.
  - Latency in_fire -> out_valid is 1 cycle.
- State ONE:
  - in_fire & out_fire -> head<=in; stay ONE (full throughput).
  - in_fire & !out_fire -> skid<=in; go FULL.
  - !in_fire & out_fire -> go EMPTY.
  - Neither -> hold.
- State FULL:
  - in_ready=0.
  - out_fire -> head<=skid; go ONE.
  - Else hold.
  - Skid entry is always younger than head; in-order delivery is guaranteed.
- Flush (sampled at posedge):
  - Next state EMPTY; head and skid valid cleared.
  - in_fire in the same cycle is discarded.
  - out_fire in the same cycle still counts as accepted by downstream.
  - Payload registers need not be cleared, but all valid-qualified outputs (out_valid, out_rd_ena, fwd_valid) are 0 the next cycle.
- Flush and reset dominate all other conditions. Flush while EMPTY is a no-op.
- Hold: when not loaded, every register retains its value. out_payload is stable while out_valid & !out_ready.
- Illegal: in_valid deasserted after assertion without in_fire is permitted (no upstream stability requirement); downstream must not rely on it.

Optional Feature:
- Macro STAGE_PERF_CNT_EN.
- When defined: adds outputs perf_stall_cnt (32, out) and perf_flush_cnt (32, out).
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - perf_flush_cnt increments each cycle with flush & (state != EMPTY).
  - Both saturate at 32'hFFFF_FFFF and are reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define file:
  - state encoding ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2
  - default widths DATA_W=64, REGADDR_W=5
  - reset-active level constant for active-low
- One natural sub-module, stage_entry_reg: single entry holding payload, rd_ena, rd_addr, fwd_data, with load enable and async reset. Instantiated twice (head, skid).
- Control FSM and forward packing stay in the top.

Test Plan:
- Reset: assert rst=0 mid-stream with both entries full -> out_valid=0, fwd_valid=2'b00, in_ready=1 asynchronously; after release, first in_fire of payload 0xA5 appears on out_payload 1 cycle later.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with rd_addr 1..8 -> one out_fire per cycle, order 1..8, in_ready never drops.
- Backpressure: out_ready=0, send A (rd 3) then B (rd 4) -> state FULL, in_ready=0, fwd_valid=2'b11, fwd_rd_addr={4,3}; release out_ready -> A then B delivered, in_ready=1 the cycle after A leaves.
- Flush in FULL with concurrent in_valid (C) -> next cycle out_valid=0, out_rd_ena=0, fwd_valid=0; C never appears on the output.
- Forward masking: entry with rd_ena=1, rd_addr=0, data 0xDEAD -> fwd_valid[0]=0; same entry with rd_addr=7 -> fwd_valid[0]=1, fwd_data low = 0xDEAD.
- With STAGE_PERF_CNT_EN: hold out_ready=0 for 5 cycles with head valid, then one flush -> perf_stall_cnt=5, perf_flush_cnt=1.
